// File: rtl/vram_console_writer_if.sv
// Byte-stream and VRAM write-port bundle for the console writer.
// The slave modport is the writer's side; master is the producer/VRAM side.
interface vram_console_writer_if;
    logic [7:0]  char_i;
    logic        char_valid_i;
    logic        char_ready_o;
    logic [11:0] vram_addr_o;
    logic [7:0]  vram_data_o;
    logic        vram_we_o;
    logic [7:0]  vram_data_i;
    logic [6:0]  cursor_x_o;
    logic [4:0]  cursor_y_o;
    logic        busy_o;

    modport slave (
        input  char_i,
        input  char_valid_i,
        output char_ready_o,
        output vram_addr_o,
        output vram_data_o,
        output vram_we_o,
        input  vram_data_i,
        output cursor_x_o,
        output cursor_y_o,
        output busy_o
    );

    modport master (
        output char_i,
        output char_valid_i,
        input  char_ready_o,
        input  vram_addr_o,
        input  vram_data_o,
        input  vram_we_o,
        output vram_data_i,
        input  cursor_x_o,
        input  cursor_y_o,
        input  busy_o
    );
endinterface

// File: rtl/vram_console_writer.sv
// Text console front end: turns a byte stream into VRAM writes, tracks the
// cursor, and scrolls/clears the screen by walking VRAM one cell per step.
module vram_console_writer #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    vram_console_writer_if.slave con
);

    typedef enum logic [2:0] {
        StIdle, StPut, StScrollRd, StScrollWr, StClrRow, StClrAll
    } state_e;

    localparam logic [6:0] LastCol       = 7'(COLS - 1);
    localparam logic [4:0] LastRow       = 5'(ROWS - 1);
    localparam logic [4:0] ScrollLastRow = 5'(ROWS - 2);
    localparam logic [7:0] Space         = 8'h20;

    state_e      st_q, st_d;
    logic [6:0]  cx_q, cx_d;
    logic [4:0]  cy_q, cy_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        we_q, we_d;
    logic        ready_q, ready_d;
    logic        scroll_q, scroll_d;

    logic        accept;
    logic        do_lf;
    logic [7:0]  tab_x;

    assign accept = con.char_valid_i && ready_q;
    assign tab_x  = ({1'b0, cx_q} | 8'h07) + 8'd1;

    // Next-state, cursor and registered VRAM port values.
    always_comb begin
        st_d     = st_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        scroll_d = scroll_q;
        do_lf    = 1'b0;

        unique case (st_q)
            StIdle: begin
                if (accept) begin
                    if (con.char_i >= 8'h20 && con.char_i != 8'h7F) begin
                        st_d   = StPut;
                        addr_d = {cy_q, cx_q};
                        data_d = con.char_i;
                        we_d   = 1'b1;
                        if (cx_q == LastCol) begin
                            cx_d = 7'd0;
                            // Bottom-right wrap: keep the row, scroll after the write.
                            if (cy_q == LastRow) scroll_d = 1'b1;
                            else                 cy_d = cy_q + 5'd1;
                        end else begin
                            cx_d = cx_q + 7'd1;
                        end
                    end else begin
                        case (con.char_i)
                            8'h0A: do_lf = 1'b1;
                            8'h0D: cx_d = 7'd0;
                            8'h08: begin
                                if (cx_q != 7'd0) begin
                                    st_d   = StPut;
                                    cx_d   = cx_q - 7'd1;
                                    addr_d = {cy_q, cx_q - 7'd1};
                                    data_d = Space;
                                    we_d   = 1'b1;
                                end
                            end
                            8'h09: begin
                                if (tab_x >= 8'(COLS)) do_lf = 1'b1;
                                else                   cx_d = tab_x[6:0];
                            end
                            8'h0C: begin
                                st_d   = StClrAll;
                                cx_d   = 7'd0;
                                cy_d   = 5'd0;
                                row_d  = 5'd0;
                                col_d  = 7'd0;
                                addr_d = 12'd0;
                                data_d = Space;
                                we_d   = 1'b1;
                            end
                            default: ;
                        endcase
                        if (do_lf) begin
                            cx_d = 7'd0;
                            if (cy_q == LastRow) begin
                                st_d   = StScrollRd;
                                row_d  = 5'd0;
                                col_d  = 7'd0;
                                addr_d = {5'd1, 7'd0};
                            end else begin
                                cy_d = cy_q + 5'd1;
                            end
                        end
                    end
                end
            end
            StPut: begin
                if (scroll_q) begin
                    scroll_d = 1'b0;
                    st_d     = StScrollRd;
                    row_d    = 5'd0;
                    col_d    = 7'd0;
                    addr_d   = {5'd1, 7'd0};
                end else begin
                    st_d = StIdle;
                end
            end
            StScrollRd: begin
                st_d   = StScrollWr;
                addr_d = {row_q, col_q};
                we_d   = 1'b1;
            end
            StScrollWr: begin
                if (col_q == LastCol) begin
                    col_d = 7'd0;
                    if (row_q == ScrollLastRow) begin
                        st_d   = StClrRow;
                        addr_d = {LastRow, 7'd0};
                        data_d = Space;
                        we_d   = 1'b1;
                    end else begin
                        st_d   = StScrollRd;
                        row_d  = row_q + 5'd1;
                        addr_d = {row_q + 5'd2, 7'd0};
                    end
                end else begin
                    st_d   = StScrollRd;
                    col_d  = col_q + 7'd1;
                    addr_d = {row_q + 5'd1, col_q + 7'd1};
                end
            end
            StClrRow: begin
                if (col_q == LastCol) begin
                    st_d = StIdle;
                end else begin
                    col_d  = col_q + 7'd1;
                    addr_d = {LastRow, col_q + 7'd1};
                    we_d   = 1'b1;
                end
            end
            StClrAll: begin
                if (col_q == LastCol) begin
                    col_d = 7'd0;
                    if (row_q == LastRow) begin
                        st_d = StIdle;
                    end else begin
                        row_d  = row_q + 5'd1;
                        addr_d = {row_q + 5'd1, 7'd0};
                        we_d   = 1'b1;
                    end
                end else begin
                    col_d  = col_q + 7'd1;
                    addr_d = {row_q, col_q + 7'd1};
                    we_d   = 1'b1;
                end
            end
            default: st_d = StIdle;
        endcase

        // Ready drops for one cycle after every accepted byte.
        ready_d = (st_d == StIdle) && !accept;
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            st_q     <= StIdle;
            cx_q     <= 7'd0;
            cy_q     <= 5'd0;
            col_q    <= 7'd0;
            row_q    <= 5'd0;
            addr_q   <= 12'd0;
            data_q   <= 8'd0;
            we_q     <= 1'b0;
            ready_q  <= 1'b0;
            scroll_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            ready_q  <= ready_d;
            scroll_q <= scroll_d;
        end
    end

    assign con.char_ready_o = ready_q;
    assign con.vram_addr_o  = addr_q;
    assign con.vram_we_o    = we_q;
    // Scroll copies read data straight through in the write cycle.
    assign con.vram_data_o  = (st_q == StScrollWr) ? con.vram_data_i : data_q;
    assign con.cursor_x_o   = cx_q;
    assign con.cursor_y_o   = cy_q;
    assign con.busy_o       = (st_q != StIdle);

endmodule
